// File: rtl/universal_shift_register.sv
// Universal shift register: parallel load, left/right shift with serial, zero,
// arithmetic or rotate fill, plus an autonomous N-step burst engine with busy/done.
module universal_shift_register #(
  parameter int unsigned WORD_LENGTH = 8,
  parameter int unsigned COUNT_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic                   shift,
  input  logic                   start,
  input  logic                   dir,
  input  logic [1:0]             mode,
  input  logic [COUNT_WIDTH-1:0] count,
  input  logic                   serialIn,
  input  logic [WORD_LENGTH-1:0] parallelInput,
  output logic                   serialOutput,
  output logic [WORD_LENGTH-1:0] parallelOutput,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned W  = WORD_LENGTH;
  localparam int unsigned CW = COUNT_WIDTH;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  localparam logic [1:0] MODE_SERIAL = 2'b00;
  localparam logic [1:0] MODE_ARITH  = 2'b10;
  localparam logic [1:0] MODE_ROTATE = 2'b11;

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic          dir_q,   dir_d;
  logic [1:0]    mode_q,  mode_d;
  logic [W-1:0]  word_q,  word_d;
  logic          done_q,  done_d;

  // One single-bit step; left=1 moves toward the MSB.
  function automatic logic [W-1:0] shift_word(
    input logic [W-1:0] r,
    input logic         left,
    input logic [1:0]   m,
    input logic         sin
  );
    logic         fill;
    logic [W-1:0] res;
    fill = 1'b0;
    if (left) begin
      case (m)
        MODE_SERIAL: fill = sin;
        MODE_ROTATE: fill = r[W-1];
        default:     fill = 1'b0;
      endcase
      res = {r[W-2:0], fill};
    end else begin
      case (m)
        MODE_SERIAL: fill = sin;
        MODE_ARITH:  fill = r[W-1];
        MODE_ROTATE: fill = r[0];
        default:     fill = 1'b0;
      endcase
      res = {fill, r[W-1:1]};
    end
    return res;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      mode_q  <= 2'b00;
      word_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      mode_q  <= mode_d;
      word_q  <= word_d;
      done_q  <= done_d;
    end
  end

  // Next state: load always wins; in IDLE start beats a single shift.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    mode_d  = mode_q;
    word_d  = word_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          word_d = parallelInput;
        end else if (start) begin
          dir_d  = dir;
          mode_d = mode;
          if (count != '0) begin
            state_d = ST_BURST;
            cnt_d   = count;
          end else begin
            done_d = 1'b1;
          end
        end else if (shift) begin
          word_d = shift_word(word_q, dir, mode, serialIn);
        end
      end
      ST_BURST: begin
        if (load) begin
          word_d  = parallelInput;
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          word_d = shift_word(word_q, dir_q, mode_q, serialIn);
          cnt_d  = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outgoing bit follows the direction that the next shift will actually use.
  logic eff_left;
  assign eff_left       = (state_q == ST_BURST) ? dir_q : dir;
  assign serialOutput   = eff_left ? word_q[W-1] : word_q[0];
  assign parallelOutput = word_q;
  assign busy           = (state_q == ST_BURST);
  assign done           = done_q;

endmodule

// File: tb/tb_universal_shift_register.sv
// Self-checking bench for universal_shift_register: directed test-plan vectors plus
// randomized shifts and bursts against an arithmetic reference model.
module tb_universal_shift_register;

  localparam int W    = 8;
  localparam int HALF = 1 << (W - 1);
  localparam int FULL = 1 << W;

  logic       clk;
  logic       reset;
  logic       load, shift, start, dir, serialIn;
  logic [1:0] mode;
  logic [3:0] count;
  logic [7:0] parallelInput;
  logic       serialOutput;
  logic [7:0] parallelOutput;
  logic       busy, done;

  int errs;
  int checks;

  universal_shift_register #(.WORD_LENGTH(8), .COUNT_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .load(load), .shift(shift), .start(start),
    .dir(dir), .mode(mode), .count(count), .serialIn(serialIn),
    .parallelInput(parallelInput), .serialOutput(serialOutput),
    .parallelOutput(parallelOutput), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference step written as integer arithmetic: halve/double plus the fill bit.
  function automatic int ref_shift(input int r, input bit d, input int m, input bit sin);
    int fill;
    if (!d) begin
      case (m)
        0:       fill = int'(sin);
        2:       fill = r / HALF;
        3:       fill = r % 2;
        default: fill = 0;
      endcase
      return r / 2 + fill * HALF;
    end
    case (m)
      0:       fill = int'(sin);
      3:       fill = r / HALF;
      default: fill = 0;
    endcase
    return (r * 2) % FULL + fill;
  endfunction

  function automatic int ref_out(input int r, input bit d);
    return d ? r / HALF : r % 2;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int v);
    parallelInput = 8'(v);
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  // Runs one burst and records what was observed; callers do the comparing.
  task automatic drive_burst(input int n, input bit d, input int m, input logic [15:0] sins,
                             output int busy_cyc, output int done_early,
                             output logic [15:0] so_seq, output logic busy_end,
                             output logic done_end, output logic done_after);
    dir = d; mode = 2'(m); count = 4'(n); start = 1'b1;
    step();
    start = 1'b0; dir = ~d; mode = ~mode; count = 4'd0;
    busy_cyc = 0; done_early = 0; so_seq = '0;
    for (int i = 0; i < n; i++) begin
      busy_cyc   += int'(busy === 1'b1);
      done_early += int'(done !== 1'b0);
      so_seq[i]  = serialOutput;
      serialIn   = sins[i];
      step();
    end
    busy_end = busy;
    done_end = done;
    step();
    done_after = done;
  endtask

  task automatic test_reset();
    checks++;
    if (parallelOutput !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || serialOutput !== 1'b0) begin
      errs++;
      $display("FAIL reset_state: got po=%h busy=%b done=%b so=%b, expected 00/0/0/0",
               parallelOutput, busy, done, serialOutput);
    end
    @(negedge clk);
    reset = 1'b1;
    step();
    checks++;
    if (parallelOutput !== 8'h00) begin
      errs++;
      $display("FAIL reset_hold: got %h expected 00", parallelOutput);
    end
  endtask

  task automatic test_burst_vectors();
    int          init_v[6] = '{'hA5, 'h81, 'h81, 'h90, 'h90, 'h00};
    bit          dir_v[6]  = '{0, 1, 1, 0, 1, 0};
    int          mode_v[6] = '{1, 3, 3, 2, 2, 0};
    int          n_v[6]    = '{3, 1, 8, 2, 2, 4};
    logic [15:0] sin_v[6]  = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h000D};
    int          want_v[6] = '{'h14, 'h03, 'h81, 'hE4, 'h40, 'hD0};
    int bc, de, r;
    logic [15:0] so, so_exp;
    logic be, dn, da;
    for (int t = 0; t < 6; t++) begin
      do_load(init_v[t]);
      r = init_v[t];
      so_exp = '0;
      for (int i = 0; i < n_v[t]; i++) begin
        so_exp[i] = ref_out(r, dir_v[t]) != 0;
        r = ref_shift(r, dir_v[t], mode_v[t], sin_v[t][i]);
      end
      drive_burst(n_v[t], dir_v[t], mode_v[t], sin_v[t], bc, de, so, be, dn, da);
      checks++;
      if (parallelOutput !== 8'(want_v[t])) begin
        errs++;
        $display("FAIL vec%0d_word: got %h expected %h", t, parallelOutput, 8'(want_v[t]));
      end
      checks++;
      if (so !== so_exp) begin
        errs++;
        $display("FAIL vec%0d_serial_out: got %b expected %b", t, so, so_exp);
      end
      checks++;
      if (bc != n_v[t] || be !== 1'b0) begin
        errs++;
        $display("FAIL vec%0d_busy: got %0d cycles end=%b expected %0d cycles end=0", t, bc, be, n_v[t]);
      end
      checks++;
      if (de != 0 || dn !== 1'b1 || da !== 1'b0) begin
        errs++;
        $display("FAIL vec%0d_done: got early=%0d end=%b after=%b expected 0/1/0", t, de, dn, da);
      end
    end
  endtask

  task automatic test_abort();
    logic seen_done;
    logic word_bad;
    do_load('h3C);
    dir = 1'b0; mode = 2'b01; count = 4'd5; start = 1'b1;
    step();
    start = 1'b1; shift = 1'b1; count = 4'd2; dir = 1'b1;
    step();
    checks++;
    if (parallelOutput !== 8'h1E || busy !== 1'b1) begin
      errs++;
      $display("FAIL abort_ignore_start: got po=%h busy=%b expected 1e/1", parallelOutput, busy);
    end
    start = 1'b0; shift = 1'b0;
    parallelInput = 8'hFF; load = 1'b1;
    step();
    load = 1'b0;
    checks++;
    if (parallelOutput !== 8'hFF || busy !== 1'b0 || done !== 1'b0) begin
      errs++;
      $display("FAIL abort_load: got po=%h busy=%b done=%b expected ff/0/0", parallelOutput, busy, done);
    end
    seen_done = 1'b0; word_bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (done !== 1'b0) seen_done = 1'b1;
      if (parallelOutput !== 8'hFF) word_bad = 1'b1;
    end
    checks++;
    if (seen_done || word_bad) begin
      errs++;
      $display("FAIL abort_quiet: got done_seen=%b word_changed=%b expected 0/0", seen_done, word_bad);
    end
  endtask

  task automatic test_count_zero();
    do_load('h5A);
    dir = 1'b0; mode = 2'b01; count = 4'd0; start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || parallelOutput !== 8'h5A) begin
      errs++;
      $display("FAIL count_zero: got done=%b busy=%b po=%h expected 1/0/5a", done, busy, parallelOutput);
    end
    step();
    checks++;
    if (done !== 1'b0 || parallelOutput !== 8'h5A) begin
      errs++;
      $display("FAIL count_zero_after: got done=%b po=%h expected 0/5a", done, parallelOutput);
    end
  endtask

  task automatic test_back_to_back();
    do_load('h0F);
    dir = 1'b0; mode = 2'b01; count = 4'd2; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || parallelOutput !== 8'h03) begin
      errs++;
      $display("FAIL b2b_first: got done=%b busy=%b po=%h expected 1/0/03", done, busy, parallelOutput);
    end
    dir = 1'b1; mode = 2'b11; count = 4'd1; start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errs++;
      $display("FAIL b2b_accept: got busy=%b done=%b expected 1/0", busy, done);
    end
    step();
    checks++;
    if (done !== 1'b1 || parallelOutput !== 8'h06) begin
      errs++;
      $display("FAIL b2b_second: got done=%b po=%h expected 1/06", done, parallelOutput);
    end
  endtask

  task automatic test_single_shift();
    int  r, pi, m, exp_v;
    bit  d, s, ld;
    for (int t = 0; t < 40; t++) begin
      r = int'($urandom_range(255));
      do_load(r);
      d = 1'($urandom); s = 1'($urandom); ld = ($urandom_range(3) == 0);
      m = int'($urandom_range(3)); pi = int'($urandom_range(255));
      dir = d; mode = 2'(m); serialIn = s; shift = 1'b1; load = ld; parallelInput = 8'(pi);
      #1;
      checks++;
      if (serialOutput !== 1'(ref_out(r, d))) begin
        errs++;
        $display("FAIL shift%0d_serial_out: got %b expected %0d", t, serialOutput, ref_out(r, d));
      end
      step();
      shift = 1'b0; load = 1'b0;
      exp_v = ld ? pi : ref_shift(r, d, m, s);
      checks++;
      if (parallelOutput !== 8'(exp_v)) begin
        errs++;
        $display("FAIL shift%0d_word: got %h expected %h (r=%h d=%0d m=%0d ld=%0d)",
                 t, parallelOutput, 8'(exp_v), 8'(r), d, m, ld);
      end
    end
  endtask

  task automatic test_random_bursts();
    int r, n, m, bc, de;
    bit d;
    logic [15:0] sins, so, so_exp;
    logic be, dn, da;
    for (int t = 0; t < 12; t++) begin
      r = int'($urandom_range(255));
      n = int'($urandom_range(15, 1));
      m = int'($urandom_range(3));
      d = 1'($urandom);
      sins = 16'($urandom);
      do_load(r);
      so_exp = '0;
      for (int i = 0; i < n; i++) begin
        so_exp[i] = ref_out(r, d) != 0;
        r = ref_shift(r, d, m, sins[i]);
      end
      drive_burst(n, d, m, sins, bc, de, so, be, dn, da);
      checks++;
      if (parallelOutput !== 8'(r) || so !== so_exp) begin
        errs++;
        $display("FAIL rburst%0d_data: got po=%h so=%b expected po=%h so=%b", t, parallelOutput, so, 8'(r), so_exp);
      end
      checks++;
      if (bc != n || be !== 1'b0 || de != 0 || dn !== 1'b1 || da !== 1'b0) begin
        errs++;
        $display("FAIL rburst%0d_handshake: got busy=%0d/%b done=%0d/%b/%b expected %0d/0 0/1/0",
                 t, bc, be, de, dn, da, n);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    do_load('hC3);
    dir = 1'b1; mode = 2'b11; count = 4'd10; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    #2 reset = 1'b0;
    #1;
    checks++;
    if (parallelOutput !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || serialOutput !== 1'b0) begin
      errs++;
      $display("FAIL reset_mid_burst: got po=%h busy=%b done=%b so=%b expected 00/0/0/0",
               parallelOutput, busy, done, serialOutput);
    end
    #1 reset = 1'b1;
    step();
    checks++;
    if (parallelOutput !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      errs++;
      $display("FAIL reset_no_resume: got po=%h busy=%b done=%b expected 00/0/0", parallelOutput, busy, done);
    end
  endtask

  initial begin
    errs = 0; checks = 0;
    reset = 1'b0; load = 1'b0; shift = 1'b0; start = 1'b0; dir = 1'b0;
    mode = 2'b00; count = 4'd0; serialIn = 1'b0; parallelInput = 8'h00;
    #3;
    test_reset();
    test_burst_vectors();
    test_abort();
    test_count_zero();
    test_back_to_back();
    test_single_shift();
    test_random_bursts();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/universal_shift_register.md
# universal_shift_register

Parametrised universal shift register: parallel load, left/right shifting with selectable fill (serial, zero, arithmetic, rotate), and an autonomous burst engine that performs N single-bit shifts on one start command with busy/done handshake. It is the next-generation replacement for the single-mode right shifter in datapaths that serialise and normalise words. Typical uses are serial transmitters, shift-add multipliers and dividers.

## Interface
- WORD_LENGTH, 8, register width in bits (≥2)
- COUNT_WIDTH, 4, width of burst shift count; max burst = 2^COUNT_WIDTH − 1

- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-low; clears all state
- load  input  1  synchronous parallel load; highest priority
- shift  input  1  single-step shift when idle
- start  input  1  launch burst of `count` shifts when idle
- dir  input  1  0 = right (toward bit 0), 1 = left (toward MSB)
- mode  input  2  00 serial fill, 01 zero fill, 10 arithmetic, 11 rotate
- count  input  COUNT_WIDTH  burst length, sampled at start
- serialIn  input  1  fill bit for mode 00
- parallelInput  input  WORD_LENGTH  load data
- serialOutput  output  1  bit that leaves on the next shift
- parallelOutput  output  WORD_LENGTH  register contents
- busy  output  1  high while burst in progress
- done  output  1  one-cycle pulse at burst completion

## Operation
- Reset (reset = 0): register = 0, state IDLE, counter = 0, busy = 0, done = 0, captured dir/mode = 0; serialOutput = 0.
- States: IDLE, BURST.
- IDLE priority per edge: load > start > shift > hold.
  - load: register ← parallelInput.
  - start: capture dir, mode, count; count ≠ 0 → BURST, counter ← count; count = 0 → stay IDLE, done pulses next cycle, no shift.
  - shift: one shift using live dir/mode.
- BURST, each edge: one shift using captured dir/mode; counter decrements; at counter = 1 the shift completes, state → IDLE, done set for one cycle.
  - load in BURST: register ← parallelInput, abort to IDLE, counter ← 0, no done.
  - start and shift in BURST: ignored.
- Shift rules (right / left):
  - 00: {serialIn, r[W−1:1]} / {r[W−2:0], serialIn}
  - 01: {0, r[W−1:1]} / {r[W−2:0], 0}
  - 10: {r[W−1], r[W−1:1]} / {r[W−2:0], 0}
  - 11: {r[0], r[W−1:1]} / {r[W−2:0], r[W−1]}
- serialIn sampled at every shifting edge, not captured at start.
- serialOutput = r[0] if effective dir = right, r[W−1] if left; effective dir = captured dir in BURST, live dir in IDLE.
- parallelOutput = register, combinational from flops.

## Timing
- Load and single shift: result visible one cycle after the sampling edge.
- Burst with count = N ≥ 1, start sampled at edge k: busy high after k; shifts at edges k+1 … k+N; after edge k+N busy = 0, done = 1 for exactly one cycle.
- count = 0: done = 1 for one cycle after edge k, busy stays 0.
- Back-to-back: start may be accepted in the cycle done is high (state already IDLE).
- Asynchronous reset mid-burst: immediate return to reset values, no done.

## Test plan
- Reset then load 0xA5; burst N = 3, dir = right, mode = 01 → parallelOutput 0x14, busy high 3 cycles, done one pulse, serialOutput sequence 1, 0, 1 before each shift.
- Load 0x81, mode 11, dir = left, N = 1 → 0x03; N = 8 from 0x81 → 0x81 (full rotate).
- Load 0x90, mode 10, dir = right, N = 2 → 0xE4; same with dir = left → 0x40.
- Mode 00, dir = right, serialIn = 1, 0, 1, 1 over a 4-shift burst from 0x00 → 0xD0.
- Load 0xFF at burst cycle 2 of N = 5 → register 0xFF, busy drops next cycle, no done; start while busy ignored; start with count = 0 → done pulse, register unchanged.
- Assert reset mid-burst → parallelOutput 0x00, busy 0, done 0 immediately.
